// File: rtl/id_pkg.sv
// Shared constants and types for the decode-side branch stage.
package id_pkg;

    // Branch opcodes (instruction[31:26])
    localparam logic [5:0] OP_BEZ = 6'b101000;
    localparam logic [5:0] OP_BNE = 6'b101001;
    localparam logic [5:0] OP_JMP = 6'b101010;

    // Instruction field bounds
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    // Control FSM: RUN = normal flow, SQUASH = ID holds a wrong-path bubble
    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_e;

    // Sign-extend the 16-bit immediate field to a 32-bit word offset
    function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_branch_stage_branch_cond.sv
// Combinational branch-condition evaluation for the instruction in ID.
module branch_cond
    import id_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output logic        cond_o
);

    // Opcode decode and operand compare
    always_comb begin
        cond_o = 1'b0;
        case (opcode_i)
            OP_BEZ:  cond_o = (rs_val_i == 32'd0);
            OP_BNE:  cond_o = (rs_val_i != rt_val_i);
            OP_JMP:  cond_o = 1'b1;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_branch_stage.sv
// IF/ID pipeline register, branch resolution/redirect, wrong-path squash
// and saturating taken-branch counter.
module id_branch_stage
    import id_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_instruction,
    input  logic             stall,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic             Br_taken,
    output logic [31:0]      Br_offset,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_instruction,
    output logic             id_valid,
    output logic [CNT_W-1:0] taken_count
);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cond;
    logic               count_inc;

    branch_cond u_cond (
        .opcode_i (instr_q[OPC_HI:OPC_LO]),
        .rs_val_i (rs_val),
        .rt_val_i (rt_val),
        .cond_o   (cond)
    );

    // Next-state, IF/ID load and redirect outputs; stall beats resolution
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        count_inc = 1'b0;
        Br_taken  = 1'b0;
        Br_offset = 32'd0;
        case (state_q)
            RUN: begin
                if (stall) begin
                    // Offset 0 with taken=1 freezes fetch PC
                    Br_taken = 1'b1;
                end else if (valid_q && cond) begin
                    Br_taken  = 1'b1;
                    Br_offset = sext_imm(instr_q[IMM_HI:IMM_LO]);
                    pc_d      = if_pc;
                    instr_d   = if_instruction;
                    valid_d   = 1'b0;
                    count_inc = 1'b1;
                    state_d   = SQUASH;
                end else begin
                    pc_d    = if_pc;
                    instr_d = if_instruction;
                    valid_d = 1'b1;
                end
            end
            SQUASH: begin
                if (stall) begin
                    Br_taken = 1'b1;
                end else begin
                    pc_d    = if_pc;
                    instr_d = if_instruction;
                    valid_d = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        // Nothing may reach fetch while reset is held
        if (!rst) begin
            Br_taken  = 1'b0;
            Br_offset = 32'd0;
        end
    end

    // Saturating taken-branch count
    always_comb begin
        cnt_d = cnt_q;
        if (count_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, IF/ID register and counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign id_pc          = pc_q;
    assign id_instruction = instr_q;
    assign id_valid       = valid_q;
    assign taken_count    = cnt_q;

endmodule

// File: tb/tb_id_branch_stage.sv
// Self-checking bench for id_branch_stage: directed scenarios plus a
// randomized stream, all checked against a behavioural pipeline model.
module tb_id_branch_stage;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [5:0] OP_BEZ = 6'b101000;
    localparam logic [5:0] OP_BNE = 6'b101001;
    localparam logic [5:0] OP_JMP = 6'b101010;
    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;

    logic             clk;
    logic             rst;
    logic [31:0]      if_pc;
    logic [31:0]      if_instruction;
    logic             stall;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic             Br_taken;
    logic [31:0]      Br_offset;
    logic [31:0]      id_pc;
    logic [31:0]      id_instruction;
    logic             id_valid;
    logic [CNT_W-1:0] taken_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: contents of ID slot, counter, fetch PC
    logic [31:0] m_pc, m_ins, fpc;
    logic        m_vld;
    int          m_cnt;

    id_branch_stage #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .stall          (stall),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .Br_taken       (Br_taken),
        .Br_offset      (Br_offset),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_valid       (id_valid),
        .taken_count    (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        logic [15:0] lo;
        lo = ins[15:0];
        return {{16{lo[15]}}, lo};
    endfunction

    function automatic logic takes(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        logic [5:0] op;
        op = ins[31:26];
        if (op == OP_BEZ) return rs == 0;
        if (op == OP_BNE) return rs != rt;
        if (op == OP_JMP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".id_pc"},    id_pc,          m_pc);
        chk({tag, ".id_instr"}, id_instruction, m_ins);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_vld});
        chk({tag, ".count"},    {{(32-CNT_W){1'b0}}, taken_count}, m_cnt);
    endtask

    task automatic model_reset();
        m_pc = 0; m_ins = 0; m_vld = 0; m_cnt = 0;
    endtask

    // One clock: drive fetch + operand inputs, check redirect, clock, check ID
    task automatic step(input string tag, input logic st, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] ins);
        logic        e_tk;
        logic [31:0] e_off;
        stall = st; rs_val = rs; rt_val = rt; if_pc = fpc; if_instruction = ins;
        #1;
        e_tk = 1'b0; e_off = 0;
        if (st) begin
            e_tk = 1'b1;
        end else if (m_vld && takes(m_ins, rs, rt)) begin
            e_tk = 1'b1; e_off = imm_of(m_ins);
        end
        chk({tag, ".br_taken"},  {31'd0, Br_taken}, {31'd0, e_tk});
        chk({tag, ".br_offset"}, Br_offset, e_off);
        if (!st) begin
            m_pc = fpc; m_ins = ins;
            m_vld = !e_tk;
            if (e_tk && m_cnt < CMAX) m_cnt++;
        end
        fpc = e_tk ? fpc + e_off : fpc + 1;
        @(posedge clk);
        #1;
        chk_regs(tag);
    endtask

    task automatic async_reset(input string tag, input logic [31:0] new_fpc);
        stall = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        chk_regs(tag);
        chk({tag, ".br_taken"},  {31'd0, Br_taken}, 32'd0);
        chk({tag, ".br_offset"}, Br_offset, 32'd0);
        stall = 1'b0;
        #1;
        rst = 1'b1;
        fpc = new_fpc;
    endtask

    initial begin
        int guard;
        logic [5:0] ops [4];
        ops[0] = OP_BEZ; ops[1] = OP_BNE; ops[2] = OP_JMP; ops[3] = OP_LW;
        rst = 1'b0; stall = 1'b0; rs_val = 0; rt_val = 0;
        if_pc = 0; if_instruction = 0; fpc = 0;
        model_reset();
        #12;
        chk_regs("por");
        chk("por.br_taken", {31'd0, Br_taken}, 32'd0);
        rst = 1'b1;

        // Straight-line code
        for (int i = 0; i < 4; i++) step("line", 1'b0, 32'd7, 32'd9, mk(OP_ADD, 16'h0003));

        // Build count=5 with id_valid=1, then reset between edges
        async_reset("rst0", 32'd0);
        for (int i = 0; i < 5; i++) begin
            step("jmp5", 1'b0, 0, 0, mk(OP_JMP, 16'h0002));
            step("jmp5b", 1'b0, 0, 0, mk(OP_ADD, 16'h0000));
        end
        step("pre", 1'b0, 0, 0, mk(OP_ADD, 16'h0000));
        chk("pre.count5", {{(32-CNT_W){1'b0}}, taken_count}, 32'd5);
        async_reset("rstmid", 32'd8);
        step("rel", 1'b0, 0, 0, mk(OP_BEZ, 16'h0004));
        chk("rel.first_pc", id_pc, 32'd8);

        // BEZ taken at pc 8 -> target 13
        step("bez", 1'b0, 32'd0, 32'd5, mk(OP_ADD, 16'h0000));
        step("bez.bub", 1'b0, 32'd1, 32'd5, mk(OP_BNE, 16'hFFFE));
        chk("bez.target", id_pc, 32'd13);

        // BNE backward, taken then not taken
        step("bne", 1'b0, 32'd3, 32'd4, mk(OP_ADD, 16'h0000));
        step("bne.bub", 1'b0, 32'd3, 32'd4, mk(OP_BNE, 16'hFFFE));
        step("bne.nt", 1'b0, 32'd4, 32'd4, mk(OP_JMP, 16'h0010));

        // JMP held under stall, then resolves
        for (int i = 0; i < 3; i++) step("stl", 1'b1, 0, 0, mk(OP_ADD, 16'h0000));
        step("stl.rel", 1'b0, 0, 0, mk(OP_ADD, 16'h0000));
        step("stl.bub", 1'b1, 0, 0, mk(OP_ADD, 16'h0000));
        step("stl.bub2", 1'b0, 0, 0, mk(OP_ADD, 16'h0000));

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = mk(ops[$urandom_range(0, 3)], 16'($urandom));
            step("rnd", ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                 $urandom_range(0, 2), ins);
        end

        // Saturation
        async_reset("rstsat", 32'h100);
        guard = 0;
        while (m_cnt < CMAX && guard < 2000) begin
            step("sat", 1'b0, 0, 0, mk(OP_JMP, 16'h0001));
            guard++;
        end
        chk("sat.reached", {{(32-CNT_W){1'b0}}, taken_count}, CMAX);
        step("sat.more", 1'b0, 0, 0, mk(OP_JMP, 16'h0001));
        step("sat.more2", 1'b0, 0, 0, mk(OP_JMP, 16'h0001));
        chk("sat.hold", {{(32-CNT_W){1'b0}}, taken_count}, CMAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
